// File: rtl/div_share_pkg.sv
// Shared definitions for the two-requester divider scheduler.
//   state_t        - scheduler FSM states
//   W_DEFAULT      - default operand width
//   DIV0_QUOTIENT  - quotient reported on divide by zero (all ones); kept
//                    32 bits wide and truncated to W at the point of use
package div_share_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_share_sched_if.sv
// Requester/scheduler bundle for div_share_sched.
//   master : client side  - drives req0/1, dividend0/1, divisor0/1
//   slave  : scheduler    - drives busy, grant, done0/1, quotient,
//                           remainder, div_by_zero
interface div_share_sched_if
    import div_share_pkg::*;
#(
    parameter int W = W_DEFAULT
) ();

    logic         req0;
    logic [W-1:0] dividend0;
    logic [W-1:0] divisor0;
    logic         req1;
    logic [W-1:0] dividend1;
    logic [W-1:0] divisor1;
    logic         busy;
    logic         grant;
    logic         done0;
    logic         done1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output req0, dividend0, divisor0,
        output req1, dividend1, divisor1,
        input  busy, grant, done0, done1, quotient, remainder, div_by_zero
    );

    modport slave (
        input  req0, dividend0, divisor0,
        input  req1, dividend1, divisor1,
        output busy, grant, done0, done1, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_restore_step.sv
// One iteration of restoring division (purely combinational).
//   a_in  : partial remainder, W+1 bits
//   q_in  : dividend/quotient shift register, W bits
//   d_in  : divisor, W bits
//   a_out : partial remainder after the iteration
//   q_out : quotient register after the iteration
module div_restore_step
#(
    parameter int W = 4
) (
    input  logic [W:0]   a_in,
    input  logic [W-1:0] q_in,
    input  logic [W-1:0] d_in,
    output logic [W:0]   a_out,
    output logic [W-1:0] q_out
);

    logic [W:0] a_shift;
    logic [W:0] a_trial;

    always_comb begin
        // {A,Q} << 1: the dividend MSB moves into the partial remainder.
        a_shift = {a_in[W-1:0], q_in[W-1]};
        a_trial = a_shift - {1'b0, d_in};
        // A borrow (sign bit set) means the divisor did not fit: restore.
        if (a_trial[W]) begin
            a_out = a_shift;
            q_out = {q_in[W-2:0], 1'b0};
        end else begin
            a_out = a_trial;
            q_out = {q_in[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one iterative restoring divider between two
// requesters with a level-request / done-pulse handshake.
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : div_share_sched_if.slave - requests/operands in; busy, grant,
//            per-requester done pulses and the shared result registers out
module div_share_sched
    import div_share_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    div_share_sched_if.slave bus
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t           state;
    logic [W:0]       a_reg;
    logic [W-1:0]     q_reg;
    logic [W-1:0]     d_reg;
    logic [W:0]       a_next;
    logic [W-1:0]     q_next;
    logic [CNT_W-1:0] cnt;
    logic             last_served;
    logic             pick;
    logic [W-1:0]     sel_dividend;
    logic [W-1:0]     sel_divisor;

    logic             busy_r;
    logic             grant_r;
    logic             done0_r;
    logic             done1_r;
    logic [W-1:0]     quot_r;
    logic [W-1:0]     rem_r;
    logic             dz_r;

    always_comb begin
        // Sole requester wins; on a tie the one not served last wins.
        pick = bus.req1;
        if (bus.req0 && bus.req1) begin
            pick = ~last_served;
        end
        sel_dividend = grant_r ? bus.dividend1 : bus.dividend0;
        sel_divisor  = grant_r ? bus.divisor1  : bus.divisor0;
    end

    div_restore_step #(.W(W)) u_step (
        .a_in  (a_reg),
        .q_in  (q_reg),
        .d_in  (d_reg),
        .a_out (a_next),
        .q_out (q_next)
    );

    // Control: FSM, arbiter, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            grant_r     <= 1'b0;
            last_served <= 1'b1;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            quot_r      <= '0;
            rem_r       <= '0;
            dz_r        <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state       <= LOAD;
                        grant_r     <= pick;
                        last_served <= pick;
                        busy_r      <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt <= CNT_W'(W - 1);
                    if (sel_divisor == '0) begin
                        state   <= DONE;
                        quot_r  <= DIV0_QUOTIENT[W-1:0];
                        rem_r   <= sel_dividend;
                        dz_r    <= 1'b1;
                        done0_r <= ~grant_r;
                        done1_r <= grant_r;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (cnt == '0) begin
                        // Capture the final iteration's result directly.
                        state   <= DONE;
                        quot_r  <= q_next;
                        rem_r   <= a_next[W-1:0];
                        dz_r    <= 1'b0;
                        done0_r <= ~grant_r;
                        done1_r <= grant_r;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_r  <= 1'b0;
                    done0_r <= 1'b0;
                    done1_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operands latched in LOAD, one restoring step per ITER cycle.
    always_ff @(posedge clk) begin
        case (state)
            LOAD: begin
                a_reg <= '0;
                q_reg <= sel_dividend;
                d_reg <= sel_divisor;
            end
            ITER: begin
                a_reg <= a_next;
                q_reg <= q_next;
            end
            default: ;
        endcase
    end

    assign bus.busy        = busy_r;
    assign bus.grant       = grant_r;
    assign bus.done0       = done0_r;
    assign bus.done1       = done1_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_div_share_sched.sv
// Self-checking bench for div_share_sched: a transaction-level model
// (countdown to completion, results from / and %) checked every cycle,
// plus directed scenarios with hand-computed expectations and a random phase.
module tb_div_share_sched;
    import div_share_pkg::*;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_share_sched_if #(.W(W)) bus ();

    div_share_sched #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid = 0;
    bit m_busy, m_grant, m_last, m_done0, m_done1, m_dz, m_in_done;
    int m_q, m_r, m_left, m_a, m_b;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_busy = 0; m_grant = 0; m_last = 1; m_done0 = 0; m_done1 = 0;
                m_dz = 0; m_in_done = 0; m_q = 0; m_r = 0; m_left = 0;
                m_valid = 1;
            end else if (m_in_done) begin
                m_in_done = 0; m_busy = 0; m_done0 = 0; m_done1 = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_in_done = 1;
                    m_q  = (m_b == 0) ? 15  : m_a / m_b;
                    m_r  = (m_b == 0) ? m_a : m_a % m_b;
                    m_dz = (m_b == 0);
                    m_done0 = !m_grant;
                    m_done1 = m_grant;
                end
            end else if (bus.req0 || bus.req1) begin
                bit p;
                p = (bus.req0 && bus.req1) ? !m_last : bus.req1;
                m_grant = p; m_last = p; m_busy = 1;
                m_a = p ? int'(bus.dividend1) : int'(bus.dividend0);
                m_b = p ? int'(bus.divisor1)  : int'(bus.divisor0);
                // edges from here to DONE: LOAD->DONE, or LOAD + W ITER cycles
                m_left = (m_b == 0) ? 1 : W + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("m_busy",  bus.busy,        m_busy);
                chk("m_grant", bus.grant,       m_grant);
                chk("m_done0", bus.done0,       m_done0);
                chk("m_done1", bus.done1,       m_done1);
                chk("m_quot",  bus.quotient,    m_q);
                chk("m_rem",   bus.remainder,   m_r);
                chk("m_dz",    bus.div_by_zero, m_dz);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic drive(input int idx, input bit r, input int a, input int b);
        if (idx == 0) begin
            bus.req0 = r; bus.dividend0 = W'(a); bus.divisor0 = W'(b);
        end else begin
            bus.req1 = r; bus.dividend1 = W'(a); bus.divisor1 = W'(b);
        end
    endtask

    task automatic wait_done(input int start, output int who, output int lat);
        who = -1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) begin
                who = bus.done0 ? 0 : 1;
                lat = cyc - start;
                break;
            end
        end
        if (who < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic run_one(input string tag, input int idx, input int a, input int b,
                           input int e_lat, input int e_q, input int e_r, input int e_dz);
        int who, lat, start;
        @(negedge clk);
        drive(idx, 1'b1, a, b);
        start = cyc;
        wait_done(start, who, lat);
        chk({tag, "_who"},   who,             idx);
        chk({tag, "_lat"},   lat,             e_lat);
        chk({tag, "_q"},     bus.quotient,    e_q);
        chk({tag, "_r"},     bus.remainder,   e_r);
        chk({tag, "_dz"},    bus.div_by_zero, e_dz);
        chk({tag, "_grant"}, bus.grant,       idx);
        chk({tag, "_other"}, idx ? bus.done0 : bus.done1, 0);
        drive(idx, 1'b0, a, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int who, lat, start, prev;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy",  bus.busy,        0);
        chk("rst_grant", bus.grant,       0);
        chk("rst_done0", bus.done0,       0);
        chk("rst_done1", bus.done1,       0);
        chk("rst_quot",  bus.quotient,    0);
        chk("rst_rem",   bus.remainder,   0);
        chk("rst_dz",    bus.div_by_zero, 0);
        reset = 1'b0;

        run_one("d13_3", 0, 13, 3, 6, 4, 1, 0);
        run_one("d15_1", 1, 15, 1, 6, 15, 0, 0);
        run_one("d7_0",  0, 7, 0, 2, 15, 7, 1);

        // simultaneous requests right after reset: req0 wins the first tie
        do_reset();
        @(negedge clk);
        drive(0, 1'b1, 9, 2);
        drive(1, 1'b1, 6, 4);
        start = cyc;
        wait_done(start, who, lat);
        chk("tie_who0", who, 0);
        chk("tie_lat0", lat, 6);
        chk("tie_q0",   bus.quotient,  4);
        chk("tie_r0",   bus.remainder, 1);
        drive(0, 1'b0, 9, 2);
        wait_done(start, who, lat);
        chk("tie_who1", who, 1);
        chk("tie_lat1", lat, 13);
        chk("tie_q1",   bus.quotient,  1);
        chk("tie_r1",   bus.remainder, 2);
        drive(1, 1'b0, 6, 4);

        // both held high: strict alternation, one done every W+3 cycles
        @(negedge clk);
        drive(0, 1'b1, 10, 3);
        drive(1, 1'b1, 11, 2);
        start = cyc;
        prev  = 0;
        for (int i = 0; i < 4; i++) begin
            wait_done(start, who, lat);
            chk("alt_who", who, i % 2);
            chk("alt_gap", lat - prev, (i == 0) ? 6 : 7);
            prev = lat;
        end
        drive(0, 1'b0, 10, 3);
        drive(1, 1'b0, 11, 2);

        // reset in the second ITER cycle of 12/5 aborts without a done
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b1, 12, 5);
        start = cyc;
        while (cyc < start + 3) @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 12, 5);
        @(negedge clk);
        chk("abort_busy",  bus.busy,        0);
        chk("abort_done0", bus.done0,       0);
        chk("abort_done1", bus.done1,       0);
        chk("abort_quot",  bus.quotient,    0);
        chk("abort_rem",   bus.remainder,   0);
        chk("abort_dz",    bus.div_by_zero, 0);
        chk("abort_grant", bus.grant,       0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_nodone", bus.done0 | bus.done1, 0);
        end

        // exhaustive operand sweep on requester 0
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_one("sweep", 0, a, b, (b == 0) ? 2 : 6,
                        (b == 0) ? 15 : a / b, (b == 0) ? a : a % b, (b == 0));
            end
        end

        // random clients: raise at random, usually drop after own done
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            if (!bus.req0) begin
                if ($urandom_range(0, 3) == 0)
                    drive(0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15));
            end else if (bus.done0 && $urandom_range(0, 3) != 0) begin
                bus.req0 = 1'b0;
            end
            if (!bus.req1) begin
                if ($urandom_range(0, 3) == 0)
                    drive(1, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15));
            end else if (bus.done1 && $urandom_range(0, 3) != 0) begin
                bus.req1 = 1'b0;
            end
            @(negedge clk);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
